// File: rtl/RgbdVoConfigPk.sv
// Shared point-cloud configuration for the RGB-D VO front end: default
// cloud component width, full cross-product width and the packed vector type.
package RgbdVoConfigPk;

    localparam int CLOUD_BW = 16;
    localparam int FULL_BW  = 2*CLOUD_BW+1;

    typedef struct packed {
        logic signed [CLOUD_BW-1:0] x;
        logic signed [CLOUD_BW-1:0] y;
        logic signed [CLOUD_BW-1:0] z;
    } cloud_vec_t;

endpackage

// File: rtl/pipe_smult.sv
// Signed IN_BW x IN_BW multiplier followed by a STAGES-deep register chain.
// Each register has its own enable so the owner can stall it stage by stage.
module pipe_smult
    import RgbdVoConfigPk::*;
#(
    parameter int IN_BW  = CLOUD_BW,
    parameter int STAGES = 2
) (
    input  logic                      i_clk,
    input  logic [STAGES-1:0]         i_en,
    input  logic signed [IN_BW-1:0]   i_a,
    input  logic signed [IN_BW-1:0]   i_b,
    output logic signed [2*IN_BW-1:0] o_p
);

    logic signed [2*IN_BW-1:0] r_p [STAGES];

    // stage boundary: product captured in r_p[0], then shifted along the chain
    always_ff @(posedge i_clk) begin
        if (i_en[0]) begin
            r_p[0] <= i_a * i_b;
        end
        for (int k = 1; k < STAGES; k++) begin
            if (i_en[k]) begin
                r_p[k] <= r_p[k-1];
            end
        end
    end

    assign o_p = r_p[STAGES-1];

endmodule

// File: rtl/cross_product_pipe.sv
// Elastic pipelined cross product n = p0 x p1 with degenerate/overflow flags.
// Build macro CROSS_PRODUCT_SAT_EN: saturate reduced components instead of wrapping.
module cross_product_pipe
    import RgbdVoConfigPk::*;
#(
    parameter int IN_BW       = CLOUD_BW,
    parameter int OUT_BW      = 2*IN_BW+1,
    parameter int MULT_STAGES = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic signed [IN_BW-1:0]  i_p0_x,
    input  logic signed [IN_BW-1:0]  i_p0_y,
    input  logic signed [IN_BW-1:0]  i_p0_z,
    input  logic signed [IN_BW-1:0]  i_p1_x,
    input  logic signed [IN_BW-1:0]  i_p1_y,
    input  logic signed [IN_BW-1:0]  i_p1_z,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic signed [OUT_BW-1:0] o_normal_x,
    output logic signed [OUT_BW-1:0] o_normal_y,
    output logic signed [OUT_BW-1:0] o_normal_z,
    output logic                     o_degenerate,
    output logic                     o_overflow
);

    localparam int PW = 2*IN_BW;
    localparam int FW = 2*IN_BW+1;

    logic [MULT_STAGES-1:0] r_vld;
    logic                   r_out_vld;
    logic [MULT_STAGES:0]   w_go;
    logic                   w_acc;

    // w_go[k]: register k may load this cycle (empty, or its content moves on)
    always_comb begin
        w_go = '0;
        w_go[MULT_STAGES] = !r_out_vld || i_ready;
        for (int k = MULT_STAGES-1; k >= 0; k--) begin
            w_go[k] = !r_vld[k] || w_go[k+1];
        end
    end

    assign o_ready = w_go[0] && !i_rst;
    assign w_acc   = i_valid && o_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
        end else begin
            if (w_go[0]) begin
                r_vld[0] <= w_acc;
            end
            for (int k = 1; k < MULT_STAGES; k++) begin
                if (w_go[k]) begin
                    r_vld[k] <= r_vld[k-1];
                end
            end
        end
    end

    logic signed [PW-1:0] w_pa, w_pb, w_pc, w_pd, w_pe, w_pf;

    pipe_smult #(.IN_BW(IN_BW), .STAGES(MULT_STAGES)) u_mul_a (
        .i_clk(i_clk), .i_en(w_go[MULT_STAGES-1:0]), .i_a(i_p0_y), .i_b(i_p1_z), .o_p(w_pa));
    pipe_smult #(.IN_BW(IN_BW), .STAGES(MULT_STAGES)) u_mul_b (
        .i_clk(i_clk), .i_en(w_go[MULT_STAGES-1:0]), .i_a(i_p0_z), .i_b(i_p1_y), .o_p(w_pb));
    pipe_smult #(.IN_BW(IN_BW), .STAGES(MULT_STAGES)) u_mul_c (
        .i_clk(i_clk), .i_en(w_go[MULT_STAGES-1:0]), .i_a(i_p0_z), .i_b(i_p1_x), .o_p(w_pc));
    pipe_smult #(.IN_BW(IN_BW), .STAGES(MULT_STAGES)) u_mul_d (
        .i_clk(i_clk), .i_en(w_go[MULT_STAGES-1:0]), .i_a(i_p0_x), .i_b(i_p1_z), .o_p(w_pd));
    pipe_smult #(.IN_BW(IN_BW), .STAGES(MULT_STAGES)) u_mul_e (
        .i_clk(i_clk), .i_en(w_go[MULT_STAGES-1:0]), .i_a(i_p0_x), .i_b(i_p1_y), .o_p(w_pe));
    pipe_smult #(.IN_BW(IN_BW), .STAGES(MULT_STAGES)) u_mul_f (
        .i_clk(i_clk), .i_en(w_go[MULT_STAGES-1:0]), .i_a(i_p0_y), .i_b(i_p1_x), .o_p(w_pf));

    logic signed [FW-1:0] w_dx, w_dy, w_dz;

    assign w_dx = FW'(w_pa) - FW'(w_pb);
    assign w_dy = FW'(w_pc) - FW'(w_pd);
    assign w_dz = FW'(w_pe) - FW'(w_pf);

    logic signed [OUT_BW-1:0] w_nx, w_ny, w_nz;
    logic                     w_ovf;

    generate
        if (OUT_BW >= FW) begin : g_ext
            assign w_nx  = OUT_BW'(w_dx);
            assign w_ny  = OUT_BW'(w_dy);
            assign w_nz  = OUT_BW'(w_dz);
            assign w_ovf = 1'b0;
        end else begin : g_red
            localparam logic signed [FW-1:0] MAXV = {{(FW-OUT_BW+1){1'b0}}, {(OUT_BW-1){1'b1}}};
            localparam logic signed [FW-1:0] MINV = ~MAXV;

            function automatic logic out_of_range(input logic signed [FW-1:0] d);
                return (d > MAXV) || (d < MINV);
            endfunction

            function automatic logic signed [OUT_BW-1:0] reduce(input logic signed [FW-1:0] d);
`ifdef CROSS_PRODUCT_SAT_EN
                if (d > MAXV) begin
                    reduce = MAXV[OUT_BW-1:0];
                end else if (d < MINV) begin
                    reduce = MINV[OUT_BW-1:0];
                end else begin
                    reduce = d[OUT_BW-1:0];
                end
`else
                reduce = d[OUT_BW-1:0];
`endif
            endfunction

            assign w_nx  = reduce(w_dx);
            assign w_ny  = reduce(w_dy);
            assign w_nz  = reduce(w_dz);
            assign w_ovf = out_of_range(w_dx) || out_of_range(w_dy) || out_of_range(w_dz);
        end
    endgenerate

    logic signed [OUT_BW-1:0] r_nx, r_ny, r_nz;
    logic                     r_degen, r_ovf;

    // stage boundary: subtract/reduce result registered as the block output
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_vld <= 1'b0;
            r_nx      <= '0;
            r_ny      <= '0;
            r_nz      <= '0;
            r_degen   <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (w_go[MULT_STAGES]) begin
            r_out_vld <= r_vld[MULT_STAGES-1];
            if (r_vld[MULT_STAGES-1]) begin
                r_nx    <= w_nx;
                r_ny    <= w_ny;
                r_nz    <= w_nz;
                r_degen <= (w_dx == '0) && (w_dy == '0) && (w_dz == '0);
                r_ovf   <= w_ovf;
            end
        end
    end

    assign o_valid      = r_out_vld;
    assign o_normal_x   = r_nx;
    assign o_normal_y   = r_ny;
    assign o_normal_z   = r_nz;
    assign o_degenerate = r_degen;
    assign o_overflow   = r_ovf;

endmodule
